// File: rtl/md_pkg.sv
// Shared types and sizing for the ring injection path.
package md_pkg;

    localparam int DEST_W    = 8;
    localparam int PAYLOAD_W = 24;

    typedef struct packed {
        logic [DEST_W-1:0]    dest_id;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    localparam int NUM_INJ_REQ    = 4;
    localparam int INJ_FIFO_DEPTH = 4;
    localparam int INJ_CNT_W      = 16;

endpackage

// File: rtl/inj_fifo.sv
// Per-requester synchronous packet FIFO; extra pointer bit distinguishes full from empty.
module inj_fifo
    import md_pkg::*;
#(
    parameter int DEPTH = INJ_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  packet_t pkt_in,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output packet_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    packet_t     mem [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= pkt_in;
    end

endmodule

// File: rtl/ring_inject_arb.sv
// Round-robin arbiter sharing one ring injection port among buffered requesters,
// with per-phase injected-packet count and end-of-phase detection.
module ring_inject_arb
    import md_pkg::*;
#(
    parameter int N_REQ   = NUM_INJ_REQ,
    parameter int F_DEPTH = INJ_FIFO_DEPTH,
    parameter int CNT_W   = INJ_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  phase_start,
    input  packet_t [N_REQ-1:0]   req_pkt,
    input  logic    [N_REQ-1:0]   req_valid,
    output logic    [N_REQ-1:0]   req_ready,
    input  logic    [N_REQ-1:0]   req_done,
    input  logic                  ring_ready,
    output packet_t               pkt_out,
    output logic                  pkt_valid,
    output logic    [CNT_W-1:0]   inj_count,
    output logic                  inject_done
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic    [N_REQ-1:0] full, empty, push, pop, done_flag;
    packet_t [N_REQ-1:0] head;
    logic    [RR_W-1:0]  rr, grant;
    logic                any_ne, out_free, xfer;
    int                  idx;

    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign out_free  = !pkt_valid || ring_ready;
    assign xfer      = pkt_valid && ring_ready;

    for (genvar r = 0; r < N_REQ; r++) begin : g_fifo
        inj_fifo #(.DEPTH(F_DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push[r]),
            .pkt_in (req_pkt[r]),
            .pop    (pop[r]),
            .full   (full[r]),
            .empty  (empty[r]),
            .head   (head[r])
        );
    end

    // First non-empty requester after the last winner, wrapping around.
    always_comb begin
        any_ne = 1'b0;
        grant  = '0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(rr) + i) % N_REQ;
            if (!any_ne && !empty[idx]) begin
                any_ne = 1'b1;
                grant  = RR_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (out_free && any_ne) pop[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_out   <= '0;
            pkt_valid <= 1'b0;
            rr        <= RR_W'(N_REQ - 1);
        end else if (out_free) begin
            if (any_ne) begin
                pkt_out   <= head[grant];
                pkt_valid <= 1'b1;
                rr        <= grant;
            end else begin
                pkt_valid <= 1'b0;
            end
        end
    end

    // A phase_start edge discards any req_done or transfer landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_count   <= '0;
            done_flag   <= '0;
            inject_done <= 1'b0;
        end else if (phase_start) begin
            inj_count   <= '0;
            done_flag   <= '0;
            inject_done <= 1'b0;
        end else begin
            if (xfer) inj_count <= inj_count + CNT_W'(1);
            done_flag   <= done_flag | req_done;
            inject_done <= (&done_flag) && (&empty) && !pkt_valid;
        end
    end

endmodule

// File: tb/tb_ring_inject_arb.sv
// Directed bench: reset, RR ordering, ring backpressure, FIFO full, phase completion, async reset.
module tb_ring_inject_arb;
    import md_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, phase_start, ring_ready;
    packet_t [3:0]        req_pkt;
    logic    [3:0]        req_valid, req_ready, req_done;
    packet_t              pkt_out;
    logic                 pkt_valid, inject_done;
    logic    [15:0]       inj_count;
    int                   errors = 0;
    int                   checks = 0;

    ring_inject_arb dut (
        .clk        (clk),
        .rst        (rst),
        .phase_start(phase_start),
        .req_pkt    (req_pkt),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_done   (req_done),
        .ring_ready (ring_ready),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .inj_count  (inj_count),
        .inject_done(inject_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic packet_t mk(input logic [7:0] d, input logic [23:0] p);
        packet_t t;
        t.dest_id = d;
        t.payload = p;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; phase_start = 1'b0; ring_ready = 1'b0;
        req_valid = '0; req_done = '0; req_pkt = '0;
        tick(); tick();
        chk("rst_valid", 64'(pkt_valid), 64'(0));
        chk("rst_pkt", 64'(pkt_out), 64'(0));
        chk("rst_cnt", 64'(inj_count), 64'(0));
        chk("rst_done", 64'(inject_done), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'hF);
        rst = 1'b0;
        tick();

        // 4 requesters x 3 packets, expect strict r0..r3 rotation at 1 pkt/cycle
        ring_ready = 1'b1;
        for (int r = 0; r < 4; r++) req_pkt[r] = mk(8'(8'h10 + r), 24'(r * 16));
        req_valid = 4'hF;
        tick();
        for (int r = 0; r < 4; r++) req_pkt[r] = mk(8'(8'h10 + r), 24'(r * 16 + 1));
        tick();
        chk("burst_v0", 64'(pkt_valid), 64'(1));
        chk("burst_p0", 64'(pkt_out), 64'(mk(8'h10, 24'h0)));
        for (int r = 0; r < 4; r++) req_pkt[r] = mk(8'(8'h10 + r), 24'(r * 16 + 2));
        tick();
        req_valid = '0;
        chk("burst_p1", 64'(pkt_out), 64'(mk(8'h11, 24'h10)));
        chk("burst_c1", 64'(inj_count), 64'(1));
        for (int j = 2; j < 12; j++) begin
            tick();
            chk("burst_v", 64'(pkt_valid), 64'(1));
            chk("burst_p", 64'(pkt_out), 64'(mk(8'(8'h10 + j % 4), 24'((j % 4) * 16 + j / 4))));
            chk("burst_c", 64'(inj_count), 64'(j));
        end
        tick();
        chk("burst_end_v", 64'(pkt_valid), 64'(0));
        chk("burst_end_c", 64'(inj_count), 64'(12));

        // Ring stall: output held, count frozen, rr not advanced
        ring_ready = 1'b0;
        req_pkt[0] = mk(8'd5, 24'hABC);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("hold_v", 64'(pkt_valid), 64'(1));
        chk("hold_p", 64'(pkt_out), 64'(mk(8'd5, 24'hABC)));
        req_pkt[0] = mk(8'd6, 24'hB0);
        req_pkt[2] = mk(8'd7, 24'hC0);
        req_valid = 4'b0101;
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk("hold_p", 64'(pkt_out), 64'(mk(8'd5, 24'hABC)));
            chk("hold_c", 64'(inj_count), 64'(12));
            tick();
        end
        ring_ready = 1'b1;
        tick();
        chk("rel_p2", 64'(pkt_out), 64'(mk(8'd7, 24'hC0)));
        chk("rel_c13", 64'(inj_count), 64'(13));
        tick();
        chk("rel_p0", 64'(pkt_out), 64'(mk(8'd6, 24'hB0)));
        chk("rel_c14", 64'(inj_count), 64'(14));
        tick();
        chk("rel_end_v", 64'(pkt_valid), 64'(0));
        chk("rel_end_c", 64'(inj_count), 64'(15));

        // New phase clears count; single packet has 2-cycle latency
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        chk("ps_cnt", 64'(inj_count), 64'(0));
        chk("ps_done", 64'(inject_done), 64'(0));
        req_pkt[0] = mk(8'd5, 24'h111);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("lat_v1", 64'(pkt_valid), 64'(0));
        tick();
        chk("lat_v2", 64'(pkt_valid), 64'(1));
        chk("lat_dest", 64'(pkt_out.dest_id), 64'(5));
        tick();
        chk("lat_v3", 64'(pkt_valid), 64'(0));
        chk("lat_cnt", 64'(inj_count), 64'(1));

        // FIFO full on req1 while output register is held
        ring_ready = 1'b0;
        req_pkt[0] = mk(8'd9, 24'hE);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            req_pkt[1] = mk(8'd1, 24'(24'hF0 + k));
            req_valid = 4'b0010;
            tick();
            chk("full_rdy", 64'(req_ready), (k < 3) ? 64'hF : 64'hD);
        end
        req_pkt[1] = mk(8'd1, 24'hF4);
        tick();
        chk("full_wait", 64'(req_ready), 64'hD);
        chk("full_hold", 64'(pkt_out), 64'(mk(8'd9, 24'hE)));
        ring_ready = 1'b1;
        tick();
        chk("full_f0", 64'(pkt_out), 64'(mk(8'd1, 24'hF0)));
        chk("full_rdy2", 64'(req_ready), 64'hF);
        tick();
        req_valid = '0;
        for (int k = 1; k < 5; k++) begin
            chk("full_fk", 64'(pkt_out), 64'(mk(8'd1, 24'(24'hF0 + k))));
            tick();
        end
        chk("full_end_v", 64'(pkt_valid), 64'(0));

        // End of phase with 2 packets still buffered
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        ring_ready = 1'b0;
        req_pkt[0] = mk(8'd2, 24'h1);
        req_pkt[1] = mk(8'd3, 24'h2);
        req_valid = 4'b0011;
        tick();
        req_valid = '0;
        req_done = 4'hF;
        tick();
        req_done = '0;
        chk("eop_d0", 64'(inject_done), 64'(0));
        tick();
        chk("eop_d1", 64'(inject_done), 64'(0));
        ring_ready = 1'b1;
        tick();
        chk("eop_d2", 64'(inject_done), 64'(0));
        tick();
        chk("eop_v", 64'(pkt_valid), 64'(0));
        chk("eop_d3", 64'(inject_done), 64'(0));
        tick();
        chk("eop_done", 64'(inject_done), 64'(1));
        chk("eop_cnt", 64'(inj_count), 64'(2));
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        chk("eop_clr", 64'(inject_done), 64'(0));
        chk("eop_clr_c", 64'(inj_count), 64'(0));

        // Asynchronous reset mid-burst
        for (int r = 0; r < 4; r++) req_pkt[r] = mk(8'(8'h20 + r), 24'(r));
        req_valid = 4'hF;
        tick();
        req_valid = '0;
        tick(); tick();
        chk("ar_pre_c", 64'(inj_count), 64'(1));
        rst = 1'b1;
        #1;
        chk("ar_v", 64'(pkt_valid), 64'(0));
        chk("ar_c", 64'(inj_count), 64'(0));
        chk("ar_rdy", 64'(req_ready), 64'hF);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("ar_post_v", 64'(pkt_valid), 64'(0));
        chk("ar_post_c", 64'(inj_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
